// File: rtl/vending_pkg.sv
// Coin codes shared between the coin acceptor and the vending FSM.
package vending_pkg;

    typedef logic [1:0] coin_code_t;

    localparam coin_code_t COIN_NONE = 2'b00;
    localparam coin_code_t COIN_5    = 2'b01;
    localparam coin_code_t COIN_10   = 2'b10;

    // FIFO entries store only the denomination: 0 = 5 rs, 1 = 10 rs.
    function automatic coin_code_t entry_to_code(input logic is_ten);
        return is_ten ? COIN_10 : COIN_5;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Downstream coin handshake between the coin acceptor and the vending FSM.
interface coin_acceptor_if;
    import vending_pkg::*;

    coin_code_t coin_code;
    logic       accept_en;

    modport master (output coin_code, input accept_en);
    modport slave  (input coin_code, output accept_en);

endinterface

// File: rtl/coin_debounce.sv
// One sensor line: two-flop synchroniser, debounce counter, rising-edge strobe
// and stuck-high detection.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise,
    output logic stuck
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int ST_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LIMIT = ST_W'(STUCK_CYCLES);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            rise_q, rise_d;
    logic [ST_W-1:0] stuck_cnt_q, stuck_cnt_d;

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d     = level_q;
        cnt_d       = '0;
        stuck_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
        if (level_q) begin
            stuck_cnt_d = (stuck_cnt_q == ST_LIMIT) ? stuck_cnt_q : stuck_cnt_q + ST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            cnt_q       <= '0;
            rise_q      <= 1'b0;
            stuck_cnt_q <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            rise_q      <= rise_d;
            stuck_cnt_q <= stuck_cnt_d;
        end
    end

    assign rise  = rise_q;
    assign stuck = (stuck_cnt_q == ST_LIMIT);

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces both sensors, rejects ambiguous or faulty events and
// buffers accepted coins in a small FIFO drained one code per cycle.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 4096,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin5_raw,
    input  logic                         coin10_raw,
    coin_acceptor_if.master              cif,
    output logic                         coin_reject,
    output logic                         coin_inhibit,
    output logic                         fault,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    logic ev5, ev10, stuck5, stuck10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_deb5 (
        .clk(clk), .rst(rst), .raw(coin5_raw), .rise(ev5), .stuck(stuck5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_deb10 (
        .clk(clk), .rst(rst), .raw(coin10_raw), .rise(ev10), .stuck(stuck10)
    );

    logic [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count, count_d;
    coin_code_t            coin_code_q, coin_code_d;
    logic                  reject_q, reject_d;
    logic                  inhibit_q, inhibit_d;
    logic                  fault_q, fault_d;
    logic                  full, empty, pop, single, push_req, push;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == PTR_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = cif.accept_en & ~empty;
    assign single   = ev5 ^ ev10;
    assign push_req = single & ~fault_q;
    // A full FIFO still takes a coin when the head leaves on the same edge.
    assign push     = push_req & (~full | pop);

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        coin_code_d = COIN_NONE;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = ev10;
            wr_ptr_d                = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            coin_code_d = entry_to_code(mem_q[rd_ptr_q[AW-1:0]]);
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end
        count_d   = wr_ptr_d - rd_ptr_d;
        fault_d   = fault_q | stuck5 | stuck10;
        reject_d  = (ev5 & ev10) | (single & fault_q) | (push_req & full & ~pop);
        inhibit_d = fault_d | (count_d == PTR_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            coin_code_q <= COIN_NONE;
            reject_q    <= 1'b0;
            inhibit_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            coin_code_q <= coin_code_d;
            reject_q    <= reject_d;
            inhibit_q   <= inhibit_d;
            fault_q     <= fault_d;
        end
    end

    assign cif.coin_code = coin_code_q;
    assign coin_reject   = reject_q;
    assign coin_inhibit  = inhibit_q;
    assign fault         = fault_q;
    assign fifo_count    = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with short debounce/stuck windows and a 4-entry FIFO.
module tb_coin_acceptor;
    import vending_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin5_raw, coin10_raw;
    logic       coin_reject, coin_inhibit, fault;
    logic [2:0] fifo_count;

    int tests_run = 0;
    int tests_failed = 0;
    int n_code5, n_code10, n_bad, n_reject, peak_count;

    coin_acceptor_if cif();

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .STUCK_CYCLES(64), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .cif(cif), .coin_reject(coin_reject), .coin_inhibit(coin_inhibit),
        .fault(fault), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Pulse and occupancy bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (cif.coin_code == COIN_5)  n_code5++;
        if (cif.coin_code == COIN_10) n_code10++;
        if (cif.coin_code == 2'b11)   n_bad++;
        if (coin_reject)              n_reject++;
        if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic c5, input logic c10, input logic acc);
        coin5_raw     = c5;
        coin10_raw    = c10;
        cif.accept_en = acc;
    endtask

    task automatic clearCounts();
        n_code5 = 0; n_code10 = 0; n_bad = 0; n_reject = 0; peak_count = 0;
    endtask

    task automatic insertCoin(input logic c5, input logic c10, input logic acc);
        applyStimulus(c5, c10, acc);
        tick(10);
        applyStimulus(1'b0, 1'b0, acc);
        tick(12);
    endtask

    initial begin
        clearCounts();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("rst_code", int'(cif.coin_code), 0);
        checkOutput("rst_reject", int'(coin_reject), 0);
        checkOutput("rst_inhibit", int'(coin_inhibit), 0);
        checkOutput("rst_fault", int'(fault), 0);
        checkOutput("rst_count", int'(fifo_count), 0);
        rst = 1'b0;
        tick(2);

        // Single 5 rs coin: code appears exactly 8 cycles after the raw rise.
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(7);
        checkOutput("lat_before", int'(cif.coin_code), int'(COIN_NONE));
        tick(1);
        checkOutput("lat_hit", int'(cif.coin_code), int'(COIN_5));
        tick(1);
        checkOutput("lat_after", int'(cif.coin_code), int'(COIN_NONE));
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(15);
        checkOutput("c5_pulses", n_code5, 1);
        checkOutput("c5_c10_pulses", n_code10, 0);
        checkOutput("c5_reject", n_reject, 0);
        checkOutput("c5_count", int'(fifo_count), 0);

        // Short glitch on the 10 rs line is ignored.
        clearCounts();
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(15);
        checkOutput("glitch_codes", n_code5 + n_code10 + n_bad, 0);
        checkOutput("glitch_reject", n_reject, 0);

        // Both sensors together: one reject, nothing queued.
        clearCounts();
        insertCoin(1'b1, 1'b1, 1'b1);
        checkOutput("both_reject", n_reject, 1);
        checkOutput("both_peak", peak_count, 0);
        checkOutput("both_codes", n_code5 + n_code10 + n_bad, 0);

        // Fill the FIFO with downstream stalled, overflow once, then drain.
        clearCounts();
        for (int i = 0; i < 4; i++) insertCoin(1'b0, 1'b1, 1'b0);
        checkOutput("fill_count", int'(fifo_count), 4);
        checkOutput("fill_inhibit", int'(coin_inhibit), 1);
        checkOutput("fill_reject", n_reject, 0);
        checkOutput("fill_codes", n_code5 + n_code10 + n_bad, 0);
        insertCoin(1'b0, 1'b1, 1'b0);
        checkOutput("ovf_reject", n_reject, 1);
        checkOutput("ovf_count", int'(fifo_count), 4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("drain%0d", i), int'(cif.coin_code), int'(COIN_10));
        end
        tick(1);
        checkOutput("drain_end_code", int'(cif.coin_code), int'(COIN_NONE));
        checkOutput("drain_end_count", int'(fifo_count), 0);
        checkOutput("drain_end_inhibit", int'(coin_inhibit), 0);
        checkOutput("drain_total", n_code10, 4);

        // 5 rs line stuck high: one genuine coin, then a sticky fault.
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(80);
        checkOutput("stuck_fault", int'(fault), 1);
        checkOutput("stuck_inhibit", int'(coin_inhibit), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(15);
        checkOutput("stuck_sticky", int'(fault), 1);
        checkOutput("stuck_c5_pulses", n_code5, 1);
        clearCounts();
        insertCoin(1'b0, 1'b1, 1'b1);
        checkOutput("fault_reject", n_reject, 1);
        checkOutput("fault_codes", n_code5 + n_code10 + n_bad, 0);
        checkOutput("fault_peak", peak_count, 0);
        checkOutput("fault_inhibit", int'(coin_inhibit), 1);

        // Reset with two coins buffered and a third mid-debounce.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        checkOutput("rerst_fault", int'(fault), 0);
        clearCounts();
        insertCoin(1'b1, 1'b0, 1'b0);
        insertCoin(1'b0, 1'b1, 1'b0);
        checkOutput("buf_count", int'(fifo_count), 2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(3);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_count", int'(fifo_count), 0);
        checkOutput("mid_rst_code", int'(cif.coin_code), 0);
        checkOutput("mid_rst_flags", int'({coin_reject, coin_inhibit, fault}), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(3);
        rst = 1'b0;
        clearCounts();
        tick(20);
        checkOutput("post_rst_codes", n_code5 + n_code10 + n_bad, 0);
        checkOutput("post_rst_count", int'(fifo_count), 0);
        checkOutput("post_rst_reject", n_reject, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
